// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types, bit-order constants and frame-length helper
//               for the SPI shift engine.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_ACTIVE = ACTIVE;

    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    // A requested length of zero or beyond the register width means a full-width frame.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_counter
// Description : Bit counter for the SPI shift engine; flags the increment
//               that completes the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] len,
    output logic             term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_cnt_next = cnt_q + CNT_W'(1);

    // High while the next increment brings the count up to the frame length.
    assign term = (w_cnt_next == len);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : Parametrised SPI data-path engine: loads a transmit word,
//               shifts a variable-length frame on external edge strobes and
//               presents the received word right-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             sampleEdge,
    input  logic             shiftEdge,
    input  logic             abort,
    input  logic             loadValid,
    output logic             loadReady,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic [CNT_W-1:0] frameLen,
    input  logic             serialDataIn,
    output logic             serialDataOut,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             wordDone,
    output logic             busy
);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             cap_q;
    logic             cap_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_d;
    logic [WIDTH-1:0] pdo_q;
    logic [WIDTH-1:0] pdo_d;
    logic             done_q;
    logic             done_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_term;

    logic [CNT_W-1:0] w_len_eff;
    logic [CNT_W-1:0] w_pad;
    logic             w_ins;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_aligned;

    assign w_len_eff = CNT_W'(eff_len(32'(frameLen), WIDTH));
    assign w_pad     = CNT_W'(WIDTH) - len_q;

    // A simultaneous sample bypasses the capture flop so the fresh bit is shifted in.
    assign w_ins = sampleEdge ? serialDataIn : cap_q;

    generate
        if (MSB_FIRST == int'(ORDER_MSB_FIRST)) begin : g_msb_first
            logic [CNT_W-1:0] w_load_pad;

            assign w_load_pad    = CNT_W'(WIDTH) - w_len_eff;
            assign w_load        = parallelDataIn << w_load_pad;
            assign w_shifted     = {sreg_q[WIDTH-2:0], w_ins};
            assign w_aligned     = w_shifted & ({WIDTH{1'b1}} >> w_pad);
            assign serialDataOut = sreg_q[WIDTH-1];
        end else begin : g_lsb_first
            assign w_load        = parallelDataIn;
            assign w_shifted     = {w_ins, sreg_q[WIDTH-1:1]};
            assign w_aligned     = w_shifted >> w_pad;
            assign serialDataOut = sreg_q[0];
        end
    endgenerate

    spi_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk    (clk),
        .resetN (resetN),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .len    (len_q),
        .term   (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cap_d   = cap_q;
        len_d   = len_q;
        pdo_d   = pdo_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (loadValid) begin
                    state_d = ST_ACTIVE;
                    len_d   = w_len_eff;
                    sreg_d  = w_load;
                    cnt_clr = 1'b1;
                end
            end

            ST_ACTIVE: begin
                // Abort outranks both strobes and leaves the last received word in place.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (sampleEdge) begin
                        cap_d = serialDataIn;
                    end
                    if (shiftEdge) begin
                        sreg_d  = w_shifted;
                        cnt_inc = 1'b1;
                        if (cnt_term) begin
                            state_d = ST_IDLE;
                            pdo_d   = w_aligned;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cap_q   <= 1'b0;
            len_q   <= '0;
            pdo_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cap_q   <= cap_d;
            len_q   <= len_d;
            pdo_q   <= pdo_d;
            done_q  <= done_d;
        end
    end

    assign loadReady       = (state_q == ST_IDLE);
    assign busy            = (state_q == ST_ACTIVE);
    assign parallelDataOut = pdo_q;
    assign wordDone        = done_q;

endmodule
`default_nettype wire
